// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// 8 data bits LSB-first, odd parity, stop, then device acknowledge check.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC   = 12000,
    parameter int unsigned START_TMO_CYC = 1500000,
    parameter int unsigned XFER_TMO_CYC  = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned MAX_AB = (INHIBIT_CYC > START_TMO_CYC) ? INHIBIT_CYC : START_TMO_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > XFER_TMO_CYC) ? MAX_AB : XFER_TMO_CYC;
    localparam int unsigned CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TMO_CYC - 1);
    localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TMO_CYC - 1);
    localparam logic [CW-1:0] REQ_LAST   = CW'(1);
    localparam logic [3:0]    LAST_BIT   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    frame_q;
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;

    logic clk_s;
    logic data_s;
    logic clk_fall;
    logic cnt_hit;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;
    // Before the first device edge the long start window applies, afterwards the transfer window.
    assign cnt_hit  = ((state_q == S_SEND) && (bit_cnt_q == 4'd0)) ? (cnt_q == START_LAST)
                                                                   : (cnt_q == XFER_LAST);

    // Two-flop pin synchronisers plus previous-clock flop for fall detection; idle lines read high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_s;
        end
    end

    // Transmit sequencer with registered line drives and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            bit_cnt_q          <= '0;
            frame_q            <= '0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            tx_busy            <= 1'b0;
            tx_done            <= 1'b0;
            tx_err             <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ps2_clk_drive_low  <= 1'b0;
                    ps2_data_drive_low <= 1'b0;
                    if (tx_start) begin
                        frame_q           <= {1'b1, ~(^tx_data), tx_data};
                        tx_busy           <= 1'b1;
                        ps2_clk_drive_low <= 1'b1;
                        cnt_q             <= '0;
                        state_q           <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q              <= '0;
                        ps2_data_drive_low <= 1'b1;
                        state_q            <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_REQ: begin
                    if (cnt_q == REQ_LAST) begin
                        // Releasing clock with data still low forms the start bit.
                        ps2_clk_drive_low <= 1'b0;
                        cnt_q             <= '0;
                        bit_cnt_q         <= '0;
                        state_q           <= S_SEND;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SEND: begin
                    if (clk_fall) begin
                        ps2_data_drive_low <= ~frame_q[bit_cnt_q];
                        bit_cnt_q          <= bit_cnt_q + 4'd1;
                        cnt_q              <= (bit_cnt_q == 4'd0) ? '0 : cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= S_ACK;
                        end
                    end else if (cnt_hit) begin
                        ps2_clk_drive_low  <= 1'b0;
                        ps2_data_drive_low <= 1'b0;
                        tx_busy            <= 1'b0;
                        tx_err             <= 1'b1;
                        state_q            <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ACK: begin
                    if (clk_fall) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (!data_s) begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            ps2_clk_drive_low  <= 1'b0;
                            ps2_data_drive_low <= 1'b0;
                            tx_busy            <= 1'b0;
                            tx_err             <= 1'b1;
                            state_q            <= S_IDLE;
                        end
                    end else if (cnt_hit) begin
                        ps2_clk_drive_low  <= 1'b0;
                        ps2_data_drive_low <= 1'b0;
                        tx_busy            <= 1'b0;
                        tx_err             <= 1'b1;
                        state_q            <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (cnt_hit) begin
                        ps2_clk_drive_low  <= 1'b0;
                        ps2_data_drive_low <= 1'b0;
                        tx_busy            <= 1'b0;
                        tx_err             <= 1'b1;
                        state_q            <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    ps2_clk_drive_low  <= 1'b0;
                    ps2_data_drive_low <= 1'b0;
                    tx_busy            <= 1'b0;
                    state_q            <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model and a
// completion scoreboard fed by the stimulus and drained by a monitor.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       is_err;
        logic       chk_bits;
        logic [9:0] bits;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [9:0] cap_bits;

    always #5 clk = ~clk;

    // Wired-AND open-drain lines with pull-ups.
    assign ps2_clk_pin  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_pin = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC  (20),
        .START_TMO_CYC(500),
        .XFER_TMO_CYC (2000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .ps2_clk_in        (ps2_clk_pin),
        .ps2_data_in       (ps2_data_pin),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .tx_busy           (tx_busy),
        .tx_done           (tx_done),
        .tx_err            (tx_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Completion monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (tx_done || tx_err)) begin
            check("done_err_exclusive", 32'(tx_done & tx_err), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion: done=%0b err=%0b expected no pulse", tx_done, tx_err);
            end else begin
                mon_e = sb_q.pop_front();
                check("completion_is_err", 32'(tx_err), 32'(mon_e.is_err));
                if (mon_e.chk_bits) check("wire_frame_bits", 32'(cap_bits), 32'(mon_e.bits));
                check("busy_cleared_at_end", 32'(tx_busy), 32'd0);
                check("lines_released_at_end", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
            end
        end
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device model. mode 0: ACK, 1: never clocks, 2: no ACK, 3: stop after fall 5.
    task automatic device(input int mode);
        int n;
        cap_bits = '0;
        n = 0;
        while (!ps2_clk_drive_low && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            fail_now("wait_inhibit");
            return;
        end
        n = 0;
        while (ps2_clk_drive_low && !ps2_data_drive_low && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_cycles", 32'(n), 32'd20);
        n = 0;
        while (ps2_clk_drive_low && ps2_data_drive_low && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("request_cycles", 32'(n), 32'd2);
        check("start_bit_clk_rel_data_low", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd1);
        if (mode == 1) begin
            n = 0;
            while (!tx_err && n < 700) begin
                @(negedge clk);
                n++;
            end
            check("start_timeout_cycles", 32'(n), 32'd500);
            return;
        end
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk_low = 1'b1;
            if (mode == 3 && i == 5) return;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) cap_bits[i-1] = ps2_data_pin;
            repeat (10) @(negedge clk);
            if (i == 10 && mode == 0) dev_data_low = 1'b1;
            repeat (10) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("completion_wait");
    endtask

    task automatic run(input logic [7:0] d, input int mode, input logic is_err,
                       input logic chk, input logic [9:0] bits);
        exp_t e;
        e.is_err   = is_err;
        e.chk_bits = chk;
        e.bits     = bits;
        sb_q.push_back(e);
        fork
            start_tx(d);
            device(mode);
        join
        wait_drain();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst          = 1'b0;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
        check("reset_data_drive", 32'(ps2_data_drive_low), 32'd0);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        check("reset_err", 32'(tx_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_lines_released", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        run(8'hED, 0, 1'b0, 1'b1, 10'h3ED);
        // 0xF4: five ones, parity 0
        run(8'hF4, 0, 1'b0, 1'b1, 10'h2F4);
        // 0x00: parity 1
        run(8'h00, 0, 1'b0, 1'b1, 10'h300);
        // silent device: start timeout
        run(8'hF4, 1, 1'b1, 1'b0, 10'h000);
        // no ACK (0x55: four ones, parity 1), then 0xFF completes
        run(8'h55, 2, 1'b1, 1'b1, 10'h355);
        run(8'hFF, 0, 1'b0, 1'b1, 10'h3FF);

        // tx_start while busy is dropped
        e.is_err   = 1'b0;
        e.chk_bits = 1'b1;
        e.bits     = 10'h3ED;
        sb_q.push_back(e);
        fork
            start_tx(8'hED);
            device(0);
            begin
                repeat (150) @(negedge clk);
                start_tx(8'h00);
            end
        join
        wait_drain();
        repeat (100) @(negedge clk);
        check("busy_start_dropped", 32'(tx_busy), 32'd0);
        check("busy_start_no_inhibit", 32'(ps2_clk_drive_low), 32'd0);

        // reset after fall 5
        fork
            start_tx(8'hED);
            device(3);
        join
        repeat (10) @(negedge clk);
        check("midframe_busy_before_reset", 32'(tx_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_clk_drive", 32'(ps2_clk_drive_low), 32'd0);
        check("midrst_data_drive", 32'(ps2_data_drive_low), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_done_err", 32'({tx_done, tx_err}), 32'd0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("post_reset_lines", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);
        check("post_reset_busy", 32'(tx_busy), 32'd0);
        run(8'hF4, 0, 1'b0, 1'b1, 10'h2F4);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
